// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI widths and packed channel payload types
package axi_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int ID_WIDTH   = 4;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    resp_e               resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    resp_e                 resp;
    logic                  last;
  } r_chan_t;

endpackage

// File: rtl/axi_fifo_ram.sv
// rtl/axi_fifo_ram.sv - FIFO storage: one synchronous write port, one asynchronous read port
module axi_fifo_ram #(
  parameter int DATA_WIDTH = axi_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  // Contents are deliberately left unreset; valid data is tracked by the controller.
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axi_sync_fifo.sv
// rtl/axi_sync_fifo.sv - single-clock valid/ready FIFO for one AXI channel payload
// Optional high-water mark and stall counter outputs are built when AXI_FIFO_STATS_EN is defined.
module axi_sync_fifo #(
  parameter int DATA_WIDTH   = axi_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int FALL_THROUGH = 0,
  parameter int AF_THRESH    = FIFO_DEPTH - 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [DATA_WIDTH-1:0]             s_data_i,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              almost_full_o
`ifdef AXI_FIFO_STATS_EN
  ,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   max_count_o,
  output logic [15:0]                       stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic             LP_FT    = (FALL_THROUGH != 0);

  logic             r_init;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic                  w_empty, w_full;
  logic                  w_push, w_pop, w_bypass_valid, w_bypass;
  logic                  w_wr_en, w_rd_en;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Ready never looks at m_ready_i, so a full FIFO refuses a push even while it is popping.
  assign s_ready_o = r_init && !flush_i && !w_full;
  assign w_push    = s_valid_i && s_ready_o;

  assign w_bypass_valid = LP_FT && w_empty && w_push;
  assign m_valid_o      = !flush_i && (!w_empty || w_bypass_valid);
  assign m_data_o       = (LP_FT && w_empty) ? s_data_i : w_rd_data;
  assign w_pop          = m_valid_o && m_ready_i;

  // A bypassed beat goes straight through, leaving pointers and count untouched.
  assign w_bypass = w_bypass_valid && m_ready_i;
  assign w_wr_en  = w_push && !w_bypass;
  assign w_rd_en  = w_pop && !w_bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_init   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_init <= 1'b1;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
      end
    end
  end

  assign count_o       = r_count;
  assign almost_full_o = (r_count >= AF_CNT);

  axi_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (PTR_W)
  ) u_ram (
    .i_clk    (clk_i),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(s_data_i),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_rd_data)
  );

`ifdef AXI_FIFO_STATS_EN
  logic [CNT_W-1:0] r_max_count;
  logic [15:0]      r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_max_count <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush_i)                    r_max_count <= '0;
      else if (r_count > r_max_count) r_max_count <= r_count;
      if (s_valid_i && !s_ready_o && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign max_count_o = r_max_count;
  assign stall_cnt_o = r_stall_cnt;
`endif

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_push && w_full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_rd_en && w_empty));
  a_count_range:  assert property (@(posedge clk_i) disable iff (!rst_ni) r_count <= FULL_CNT);

endmodule

// File: tb/tb_axi_sync_fifo.sv
// tb/tb_axi_sync_fifo.sv - scoreboard bench driving a registered and a fall-through FIFO in lockstep
module tb_axi_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         m_ready = 1'b0;

  logic          s_ready   [2];
  logic          m_valid   [2];
  logic [W-1:0]  m_data    [2];
  logic [CW-1:0] count     [2];
  logic          af        [2];
`ifdef AXI_FIFO_STATS_EN
  logic [CW-1:0] max_count [2];
  logic [15:0]   stall_cnt [2];
`endif

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int  m_count[2];
  int  peak[2];
  int  stalls[2];
  bit  m_init;

  always #5 clk = ~clk;

  axi_sync_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .FALL_THROUGH(0), .AF_THRESH(AF)) u_ft0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_ready_o(s_ready[0]), .s_data_i(s_data),
    .m_valid_o(m_valid[0]), .m_ready_i(m_ready), .m_data_o(m_data[0]),
    .count_o(count[0]), .almost_full_o(af[0])
`ifdef AXI_FIFO_STATS_EN
    , .max_count_o(max_count[0]), .stall_cnt_o(stall_cnt[0])
`endif
  );

  axi_sync_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .FALL_THROUGH(1), .AF_THRESH(AF)) u_ft1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_ready_o(s_ready[1]), .s_data_i(s_data),
    .m_valid_o(m_valid[1]), .m_ready_i(m_ready), .m_data_o(m_data[1]),
    .count_o(count[1]), .almost_full_o(af[1])
`ifdef AXI_FIFO_STATS_EN
    , .max_count_o(max_count[1]), .stall_cnt_o(stall_cnt[1])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output beat is matched against the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n && m_valid[0] && m_ready) begin
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ft0_data: got %0h expected nothing at %0t", m_data[0], $time);
      end else chk("ft0_data", int'(m_data[0]), int'(q0.pop_front()));
    end
    if (rst_n && m_valid[1] && m_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ft1_data: got %0h expected nothing at %0t", m_data[1], $time);
      end else chk("ft1_data", int'(m_data[1]), int'(q1.pop_front()));
    end
  end

  // One clock of stimulus; inputs applied just after a rising edge, outputs checked at the falling edge.
  task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr, input logic fl);
    bit e_rdy[2], e_val[2], e_push[2], e_pop[2], byp;
    int nxt[2];
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    for (int i = 0; i < 2; i++) begin
      e_rdy[i]  = m_init && !fl && (m_count[i] != D);
      e_push[i] = sv && e_rdy[i];
      byp       = (i == 1) && (m_count[i] == 0);
      e_val[i]  = !fl && ((m_count[i] != 0) || (byp && e_push[i]));
      e_pop[i]  = e_val[i] && mr;
      if (e_push[i]) begin
        if (i == 0) q0.push_back(sd);
        else        q1.push_back(sd);
      end
      if (sv && !e_rdy[i]) stalls[i]++;
      if (fl)                            nxt[i] = 0;
      else if (byp && e_push[i] && e_pop[i]) nxt[i] = m_count[i];
      else nxt[i] = m_count[i] + int'(e_push[i]) - int'(e_pop[i]);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ft%0d_ready", i), int'(s_ready[i]), int'(e_rdy[i]));
      chk($sformatf("ft%0d_valid", i), int'(m_valid[i]), int'(e_val[i]));
      chk($sformatf("ft%0d_count", i), int'(count[i]), m_count[i]);
      chk($sformatf("ft%0d_afull", i), int'(af[i]), int'(m_count[i] >= AF));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = nxt[i];
      if (fl) peak[i] = 0;
      else if (m_count[i] > peak[i]) peak[i] = m_count[i];
    end
    if (fl) begin
      q0.delete();
      q1.delete();
    end
    m_init = 1'b1;
  endtask

  initial begin
    logic         r_sv, r_mr, r_fl;
    logic [W-1:0] r_sd;
    m_init = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; peak[i] = 0; stalls[i] = 0;
    end

    // Reset held for three cycles: everything quiet, ready low.
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst%0d_ready", i), int'(s_ready[i]), 0);
        chk($sformatf("rst%0d_valid", i), int'(m_valid[i]), 0);
        chk($sformatf("rst%0d_count", i), int'(count[i]), 0);
        chk($sformatf("rst%0d_afull", i), int'(af[i]), 0);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full with no drain, try one refused push, then drain in order.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with simultaneous pop: head leaves, push refused.
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    step(1'b1, 8'h63, 1'b0, 1'b0);
    step(1'b1, 8'h64, 1'b0, 1'b0);
    step(1'b1, 8'h65, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 8'h70 + 8'(k), 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty FIFO: fall-through delivers A5 this cycle, registered one a cycle later.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 3 with traffic on both sides.
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hB3, 1'b0, 1'b0);
    step(1'b1, 8'hB0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      r_sv = 1'($urandom_range(0, 1));
      r_mr = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 63) == 0);
      r_sd = W'($urandom);
      step(r_sv, r_sd, r_mr, r_fl);
    end
    repeat (D + 2) step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef AXI_FIFO_STATS_EN
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ft%0d_max_count", i), int'(max_count[i]), peak[i]);
      chk($sformatf("ft%0d_stall_cnt", i), int'(stall_cnt[i]), stalls[i]);
    end
`endif
    chk("ft0_q_drained", q0.size(), 0);
    chk("ft1_q_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sync_fifo.md
Name: axi_sync_fifo

Overview:
- Single-clock, parametrised valid/ready FIFO that carries one AXI channel payload (AW, W, B, AR or R) as a flat vector.
- Next generation of the team's AXI channel buffering. Generalises width and depth, and adds:
  - a fall-through (zero-latency) mode,
  - occupancy and almost-full reporting,
  - synchronous flush.
- Instantiated per channel inside AXI interconnect and bridge blocks to decouple timing and absorb bursts.
- Preserves AXI handshake rules and strict in-order delivery.

Parameters:
- DATA_WIDTH, 64, payload width in bits; the instantiator sets it to $bits of the channel struct.
- FIFO_DEPTH, 8, number of entries; power of two, >= 2.
- FALL_THROUGH, 0, 1 = empty FIFO bypasses storage combinationally; 0 = registered output.
- AF_THRESH, FIFO_DEPTH-1, occupancy at or above which almost_full_o asserts; range 1..FIFO_DEPTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous discard of all entries.
- s_valid_i  in  1  upstream valid.
- s_ready_o  out  1  upstream ready.
- s_data_i  in  DATA_WIDTH  upstream payload.
- m_valid_o  out  1  downstream valid.
- m_ready_i  in  1  downstream ready.
- m_data_o  out  DATA_WIDTH  downstream payload.
- count_o  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- almost_full_o  out  1  count_o >= AF_THRESH.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset state:
  - Pointers = 0, count_o = 0, m_valid_o = 0, almost_full_o = 0.
  - s_ready_o = 0 while rst_ni is low; it rises on the first clk_i edge after deassertion, via a registered init flag.
  - Storage array is not reset.
- Handshakes:
  - Push occurs when s_valid_i && s_ready_o; pop occurs when m_valid_o && m_ready_i.
  - s_ready_o = init && !flush_i && (count != FIFO_DEPTH). It never depends combinationally on m_ready_i, so a push is refused when full even if a pop happens in the same cycle.
- FALL_THROUGH=0:
  - m_valid_o = (count != 0) && !flush_i; m_data_o = mem[rd_ptr].
  - Latency from push to m_valid_o is 1 cycle.
- FALL_THROUGH=1:
  - When count == 0: m_valid_o = s_valid_i && s_ready_o and m_data_o = s_data_i, both combinational.
  - A push and pop in the same cycle on an empty FIFO bypasses storage; pointers and count are unchanged.
  - Otherwise the behaviour is identical to FALL_THROUGH=0.
- Counting:
  - Push only: count +1. Pop only: count -1. Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- Stability: while m_valid_o && !m_ready_i, m_data_o holds. In fall-through bypass, stability is inherited from the upstream AXI rule.
- Flush:
  - While flush_i is high, s_ready_o = 0 and m_valid_o = 0; no handshake can occur.
  - On the next edge, pointers and count = 0.
  - Flush takes priority over all traffic.
- Reset mid-transfer: all in-flight entries are lost and outputs return to their reset values immediately (asynchronous).
- Simulation assertions: push when full is impossible; pop when empty is impossible; count_o <= FIFO_DEPTH.

Optional Feature:
- Macro: AXI_FIFO_STATS_EN.
- When defined, two extra outputs are present:
  - max_count_o [$clog2(FIFO_DEPTH+1)]: high-water mark of count_o, cleared by reset and by flush_i.
  - stall_cnt_o [16]: saturating count of cycles with s_valid_i && !s_ready_o, cleared by reset only, holds at 16'hFFFF.
- When undefined, these ports and their logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package axi_pkg holds:
  - default width constants ADDR_WIDTH=32, DATA_WIDTH=64, ID_WIDTH=4;
  - packed channel typedefs aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t, used by instantiators to size DATA_WIDTH.
- Sub-module axi_fifo_ram: FIFO_DEPTH x DATA_WIDTH register array with one synchronous write port and one asynchronous read port. Control logic stays in axi_sync_fifo.

Test Plan:
- Reset/init (DEPTH=4, WIDTH=8): hold rst_ni low for 3 cycles, then release → s_ready_o=0 during reset and 1 one edge after release; count_o=0; m_valid_o=0.
- Fill/drain: push 8'h11, 22, 33, 44 with m_ready_i=0 → count_o=4, s_ready_o=0, almost_full_o=1 from count 3. Then m_ready_i=1 → outputs 11, 22, 33, 44 in order and count_o returns to 0.
- Full + simultaneous pop: at count 4 with s_valid_i=1 and m_ready_i=1 → pop of the head only, push refused, count_o=3 the next cycle. With count 2 and push+pop → count_o stays 2 and the pointers wrap correctly over 10 iterations.
- Fall-through (FALL_THROUGH=1): empty FIFO, s_valid_i=1, s_data_i=8'hA5, m_ready_i=1 → m_valid_o=1 and m_data_o=A5 in the same cycle, count_o stays 0. FALL_THROUGH=0 → A5 appears one cycle later.
- Flush: count 3, assert flush_i for 1 cycle with s_valid_i=1 and m_ready_i=1 → no handshake that cycle, count_o=0 the next cycle, m_valid_o=0.
- Random backpressure plus stats: 1000 random valid/ready cycles checked against a scoreboard. With AXI_FIFO_STATS_EN defined: max_count_o equals the observed peak, and stall_cnt_o equals the number of refused cycles.
